// File: rtl/arith_batch_pkg.sv
// Shared types and bit-layout helpers for the batch arithmetic engine.
// Holds the sequencer state encoding and the line/status field offsets.
package arith_batch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        ISSUE,
        DRAIN,
        RESPOND,
        FLUSH
    } state_t;

    localparam int STATUS_DONE_BIT  = 0;
    localparam int STATUS_CLAMP_BIT = 1;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int RESULT_BASE      = 32;

    // Operand a of pair i sits in the even word of the input line.
    function automatic int a_lsb(input int i, input int dw);
        return 2 * i * dw;
    endfunction

    // Operand b of pair i sits in the odd word of the input line.
    function automatic int b_lsb(input int i, input int dw);
        return (2 * i + 1) * dw;
    endfunction

    // Result i is packed after the status word in the output line.
    function automatic int res_lsb(input int i, input int dw);
        return RESULT_BASE + i * dw;
    endfunction

endpackage

// File: rtl/issue_latency_tracker.sv
// Delays the issue strobe by the arithmetic unit's fixed latency so the
// sequencer knows in which cycle each result is valid.
module issue_latency_tracker #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic issue,
    output logic capture
);

    logic [DEPTH-1:0] sr;

    // Shift the issue strobe; flush discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(issue);
        end
    end

    assign capture = sr[DEPTH-1];

endmodule

// File: rtl/arith_batch_engine.sv
// Unpacks operand pairs from one cache line, issues them to a pipelined
// arithmetic unit, captures the results and returns them in one line.
module arith_batch_engine
    import arith_batch_pkg::*;
#(
    parameter int DATA_LEN       = 32,
    parameter int LINE_BITS      = 512,
    parameter int PIPELINE_STAGE = 2,
    parameter int ISSUE_INTERVAL = 1,
    localparam int MAX_PAIRS     = LINE_BITS / (2 * DATA_LEN),
    localparam int CW            = $clog2(MAX_PAIRS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 soft_reset,
    input  logic                 start,
    input  logic [CW-1:0]        num_pairs,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LINE_BITS-1:0] in_data,
    output logic                 dut_issue,
    output logic [DATA_LEN-1:0]  dut_a,
    output logic [DATA_LEN-1:0]  dut_b,
    input  logic [DATA_LEN-1:0]  dut_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LINE_BITS-1:0] out_data,
    output logic                 busy,
    output logic [31:0]          done_count
);

    localparam int IW = $clog2(ISSUE_INTERVAL + 1);
    localparam int FW = (PIPELINE_STAGE > 1) ?
                        $clog2(PIPELINE_STAGE) : 1;

    if (RESULT_BASE + MAX_PAIRS * DATA_LEN > LINE_BITS) begin : g_bad_line
        $error("result line cannot hold MAX_PAIRS results");
    end
    if (PIPELINE_STAGE < 1) begin : g_bad_lat
        $error("PIPELINE_STAGE must be at least 1");
    end
    if (ISSUE_INTERVAL < 1) begin : g_bad_ivl
        $error("ISSUE_INTERVAL must be at least 1");
    end

    state_t                             state;
    logic [LINE_BITS-1:0]               line_q;
    logic [CW-1:0]                      n_q;
    logic [CW-1:0]                      iss_cnt;
    logic [CW-1:0]                      cap_cnt;
    logic [CW-1:0]                      cap_next;
    logic [CW-1:0]                      n_eff;
    logic                               clamp_d;
    logic                               clamp_q;
    logic [IW-1:0]                      ivl;
    logic [FW-1:0]                      fcnt;
    logic [MAX_PAIRS-1:0][DATA_LEN-1:0] res_q;
    logic                               cap_vld;
    logic                               cap_en;

    issue_latency_tracker #(
        .DEPTH(PIPELINE_STAGE)
    ) u_tracker (
        .clk    (clk),
        .reset  (reset),
        .flush  (soft_reset),
        .issue  (dut_issue),
        .capture(cap_vld)
    );

    assign cap_en   = cap_vld && (state != FLUSH);
    assign cap_next = cap_cnt + CW'(cap_en);
    assign busy     = (state != IDLE);

    // Clamp the requested pair count to what one line can carry.
    always_comb begin
        n_eff   = num_pairs;
        clamp_d = 1'b0;
        if (num_pairs > CW'(MAX_PAIRS)) begin
            n_eff   = CW'(MAX_PAIRS);
            clamp_d = 1'b1;
        end
    end

    // Assemble the response line from status and captured results.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data[STATUS_DONE_BIT]  = 1'b1;
            out_data[STATUS_CLAMP_BIT] = clamp_q;
            out_data[STATUS_COUNT_LSB +: 8] = 8'(n_q);
            for (int i = 0; i < MAX_PAIRS; i++) begin
                out_data[res_lsb(i, DATA_LEN) +: DATA_LEN] = res_q[i];
            end
        end
    end

    // Batch sequencer: accept line, issue pairs, drain, respond, flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            line_q     <= '0;
            n_q        <= '0;
            iss_cnt    <= '0;
            cap_cnt    <= '0;
            clamp_q    <= 1'b0;
            ivl        <= '0;
            fcnt       <= '0;
            res_q      <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            dut_issue  <= 1'b0;
            dut_a      <= '0;
            dut_b      <= '0;
            done_count <= '0;
        end else if (soft_reset) begin
            state     <= FLUSH;
            n_q       <= '0;
            iss_cnt   <= '0;
            cap_cnt   <= '0;
            clamp_q   <= 1'b0;
            ivl       <= '0;
            fcnt      <= '0;
            res_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            dut_issue <= 1'b0;
            dut_a     <= '0;
            dut_b     <= '0;
        end else begin
            if (cap_en) begin
                for (int i = 0; i < MAX_PAIRS; i++) begin
                    if (cap_cnt == CW'(i)) begin
                        res_q[i] <= dut_result;
                    end
                end
                cap_cnt <= cap_next;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_q     <= n_eff;
                        clamp_q <= clamp_d;
                        if (n_eff == '0) begin
                            state     <= RESPOND;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= WAIT_LINE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                WAIT_LINE: begin
                    if (in_valid && in_ready) begin
                        line_q    <= in_data;
                        in_ready  <= 1'b0;
                        dut_issue <= 1'b1;
                        dut_a <= in_data[a_lsb(0, DATA_LEN) +: DATA_LEN];
                        dut_b <= in_data[b_lsb(0, DATA_LEN) +: DATA_LEN];
                        iss_cnt   <= CW'(1);
                        ivl       <= IW'(1);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (iss_cnt == n_q) begin
                        dut_issue <= 1'b0;
                        dut_a     <= '0;
                        dut_b     <= '0;
                        state     <= DRAIN;
                    end else if (ivl == IW'(ISSUE_INTERVAL)) begin
                        dut_issue <= 1'b1;
                        dut_a <= line_q[a_lsb(int'(iss_cnt), DATA_LEN)
                                        +: DATA_LEN];
                        dut_b <= line_q[b_lsb(int'(iss_cnt), DATA_LEN)
                                        +: DATA_LEN];
                        iss_cnt   <= iss_cnt + CW'(1);
                        ivl       <= IW'(1);
                    end else begin
                        dut_issue <= 1'b0;
                        dut_a     <= '0;
                        dut_b     <= '0;
                        ivl       <= ivl + IW'(1);
                    end
                end
                DRAIN: begin
                    if (cap_next == n_q) begin
                        state     <= RESPOND;
                        out_valid <= 1'b1;
                    end
                end
                RESPOND: begin
                    if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        done_count <= done_count + 32'd1;
                        res_q      <= '0;
                        cap_cnt    <= '0;
                        iss_cnt    <= '0;
                        n_q        <= '0;
                        clamp_q    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                FLUSH: begin
                    if (fcnt == FW'(PIPELINE_STAGE - 1)) begin
                        state <= IDLE;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_batch_engine.sv
// Directed bench: two engines (issue interval 1 and 2) each feeding a
// two-stage multiplier model; expected values are hand-computed.
module tb_arith_batch_engine;

    logic         clk;
    logic         reset;
    logic         soft_reset;
    logic         start1;
    logic         start2;
    logic [3:0]   num_pairs;
    logic         in_valid;
    logic [511:0] in_data;
    logic         out_ready;

    logic         in_ready1, in_ready2;
    logic         dut_issue1, dut_issue2;
    logic [31:0]  dut_a1, dut_b1, dut_a2, dut_b2;
    logic [31:0]  dut_result1, dut_result2;
    logic         out_valid1, out_valid2;
    logic [511:0] out_data1, out_data2;
    logic         busy1, busy2;
    logic [31:0]  done_count1, done_count2;

    logic [31:0]  m1s1, m1s2, m2s1, m2s2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic         sel;
    logic         in_ready_s, out_valid_s, dut_issue_s;
    logic [31:0]  dut_a_s, dut_b_s;
    logic [511:0] out_data_s;

    int iss_t[16];
    int nissue;
    int zviol;

    arith_batch_engine #(
        .DATA_LEN(32), .LINE_BITS(512),
        .PIPELINE_STAGE(2), .ISSUE_INTERVAL(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .soft_reset(soft_reset),
        .start(start1), .num_pairs(num_pairs),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .dut_issue(dut_issue1), .dut_a(dut_a1), .dut_b(dut_b1),
        .dut_result(dut_result1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .busy(busy1), .done_count(done_count1)
    );

    arith_batch_engine #(
        .DATA_LEN(32), .LINE_BITS(512),
        .PIPELINE_STAGE(2), .ISSUE_INTERVAL(2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .soft_reset(soft_reset),
        .start(start2), .num_pairs(num_pairs),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .dut_issue(dut_issue2), .dut_a(dut_a2), .dut_b(dut_b2),
        .dut_result(dut_result2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .busy(busy2), .done_count(done_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Two-stage multipliers standing in for the unit under test.
    always @(posedge clk) begin
        m1s1 <= dut_a1 * dut_b1;
        m1s2 <= m1s1;
        m2s1 <= dut_a2 * dut_b2;
        m2s2 <= m2s1;
    end
    assign dut_result1 = m1s2;
    assign dut_result2 = m2s2;

    assign in_ready_s  = sel ? in_ready2  : in_ready1;
    assign out_valid_s = sel ? out_valid2 : out_valid1;
    assign dut_issue_s = sel ? dut_issue2 : dut_issue1;
    assign dut_a_s     = sel ? dut_a2     : dut_a1;
    assign dut_b_s     = sel ? dut_b2     : dut_b1;
    assign out_data_s  = sel ? out_data2  : out_data1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] res(input logic [511:0] d,
                                        input int i);
        return d[32 + i*32 +: 32];
    endfunction

    // Start a batch, optionally supply the line, wait for out_valid.
    task automatic run_batch(input logic which, input int np,
                             input logic [511:0] line,
                             input logic with_line,
                             output int lat, output int wait_ir,
                             output logic saw_ir);
        int n;
        int t_acc;
        sel       = which;
        num_pairs = np[3:0];
        if (which) start2 = 1'b1;
        else       start1 = 1'b1;
        tick();
        start1  = 1'b0;
        start2  = 1'b0;
        t_acc   = cyc;
        saw_ir  = 1'b0;
        wait_ir = 0;
        if (with_line) begin
            n = 0;
            while (!in_ready_s && n < 20) begin
                tick();
                n++;
            end
            wait_ir = n;
            check("in_ready_to", in_ready_s, 1);
            in_valid = 1'b1;
            in_data  = line;
            tick();
            in_valid = 1'b0;
            t_acc    = cyc;
        end
        nissue = 0;
        zviol  = 0;
        n = 0;
        while (!out_valid_s && n < 100) begin
            if (in_ready_s) saw_ir = 1'b1;
            if (dut_issue_s) begin
                if (nissue < 16) iss_t[nissue] = cyc - t_acc;
                nissue++;
            end else if ((dut_a_s | dut_b_s) != 0) begin
                zviol++;
            end
            tick();
            n++;
        end
        check("out_valid_to", out_valid_s, 1);
        lat = cyc - t_acc;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [511:0] line;
        logic [63:0]  snap;
        logic         saw_ir;
        int           lat;
        int           wir;
        int           unstable;
        logic [31:0]  dc1;

        reset      = 1'b1;
        soft_reset = 1'b0;
        start1     = 1'b0;
        start2     = 1'b0;
        num_pairs  = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        sel        = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  in_ready1,  0);
        check("rst_out_valid", out_valid1, 0);
        check("rst_issue",     dut_issue1, 0);
        check("rst_busy",      busy1,      0);
        check("rst_dut_a",     dut_a1,     0);
        check("rst_done_cnt",  done_count1, 0);
        check("rst_out_data",  |out_data1, 0);
        reset = 1'b0;
        tick();

        // Two pairs, interval 1: (3,5),(7,11).
        line = '0;
        line[31:0]    = 32'd3;
        line[63:32]   = 32'd5;
        line[95:64]   = 32'd7;
        line[127:96]  = 32'd11;
        run_batch(1'b0, 2, line, 1'b1, lat, wir, saw_ir);
        check("t1_lat",    lat, 4);
        check("t1_status", out_data1[31:0], 32'h201);
        check("t1_r0",     res(out_data1, 0), 15);
        check("t1_r1",     res(out_data1, 1), 77);
        check("t1_upper",  |out_data1[511:96], 0);
        check("t1_issues", nissue, 2);
        ack();
        check("t1_done", done_count1, 1);
        check("t1_ov_lo", out_valid1, 0);

        // Eight pairs (i,i+1), interval 2.
        line = '0;
        for (int i = 0; i < 8; i++) begin
            line[64*i +: 32]    = 32'(i);
            line[64*i+32 +: 32] = 32'(i + 1);
        end
        run_batch(1'b1, 8, line, 1'b1, lat, wir, saw_ir);
        check("t2_lat",    lat, 17);
        check("t2_status", out_data2[31:0], 32'h801);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_r%0d", i), res(out_data2, i),
                  64'(i * (i + 1)));
        end
        check("t2_issues", nissue, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_iss%0d", k), iss_t[k], 64'(2 * k));
        end
        check("t2_a_zero", zviol, 0);
        ack();
        check("t2_done", done_count2, 1);

        // Request 12 pairs on an 8-pair line: clamp.
        line = '0;
        for (int i = 0; i < 8; i++) begin
            line[64*i +: 32]    = 32'(i + 2);
            line[64*i+32 +: 32] = 32'd3;
        end
        run_batch(1'b0, 12, line, 1'b1, lat, wir, saw_ir);
        check("t3_lat",    lat, 10);
        check("t3_status", out_data1[31:0], 32'h803);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_r%0d", i), res(out_data1, i),
                  64'(3 * (i + 2)));
        end
        check("t3_issues", nissue, 8);
        ack();
        check("t3_done", done_count1, 2);

        // Zero pairs: immediate response, no line requested.
        run_batch(1'b0, 0, '0, 1'b0, lat, wir, saw_ir);
        check("t4_lat",    lat, 0);
        check("t4_no_ir",  saw_ir, 0);
        check("t4_ir",     in_ready1, 0);
        check("t4_status", out_data1[31:0], 32'h001);
        check("t4_res0",   |out_data1[511:32], 0);
        ack();
        check("t4_done", done_count1, 3);

        // Soft reset after three issues of an eight-pair batch.
        line = '0;
        for (int i = 0; i < 8; i++) begin
            line[64*i +: 32]    = 32'(i + 10);
            line[64*i+32 +: 32] = 32'd2;
        end
        dc1       = done_count1;
        sel       = 1'b0;
        num_pairs = 4'd8;
        start1    = 1'b1;
        tick();
        start1    = 1'b0;
        check("t5_ir", in_ready1, 1);
        in_valid = 1'b1;
        in_data  = line;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("t5_iss2", dut_a1, 12);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check("t5_f_issue", dut_issue1, 0);
        check("t5_f_ov",    out_valid1, 0);
        check("t5_f_ir",    in_ready1,  0);
        check("t5_f_busy0", busy1, 1);
        tick();
        check("t5_f_busy1", busy1, 1);
        check("t5_f_data",  |out_data1, 0);
        tick();
        check("t5_idle",    busy1, 0);
        check("t5_dc_keep", done_count1, dc1);
        line = '0;
        line[31:0]  = 32'd6;
        line[63:32] = 32'd7;
        run_batch(1'b0, 1, line, 1'b1, lat, wir, saw_ir);
        check("t5_ir_wait", wir, 0);
        check("t5_lat",     lat, 3);
        check("t5_status",  out_data1[31:0], 32'h101);
        check("t5_r0",      res(out_data1, 0), 42);
        check("t5_stale",   |out_data1[511:64], 0);
        ack();
        check("t5_done", done_count1, dc1 + 1);

        // Hold off the response; start must be ignored meanwhile.
        line = '0;
        line[31:0]  = 32'd9;
        line[63:32] = 32'd9;
        run_batch(1'b0, 1, line, 1'b1, lat, wir, saw_ir);
        dc1      = done_count1;
        snap     = out_data1[63:0];
        unstable = 0;
        start1   = 1'b1;
        num_pairs = 4'd2;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (out_data1[63:0] !== snap || !out_valid1) unstable++;
            if (in_ready1) unstable++;
            tick();
        end
        check("t6_stable", unstable, 0);
        check("t6_r0",     res(out_data1, 0), 81);
        check("t6_ov",     out_valid1, 1);
        ack();
        check("t6_done",   done_count1, dc1 + 1);
        check("t6_ov_lo",  out_valid1, 0);
        check("t6_ir_lo",  in_ready1, 0);
        line = '0;
        line[31:0]  = 32'd2;
        line[63:32] = 32'd3;
        run_batch(1'b0, 1, line, 1'b1, lat, wir, saw_ir);
        check("t6_b2b_ir", wir, 0);
        check("t6_b2b_r0", res(out_data1, 0), 6);
        ack();
        tick();
        tick();
        check("t6_done2", done_count1, dc1 + 2);

        // Hard reset in the middle of a batch.
        line = '0;
        line[31:0]  = 32'd4;
        line[63:32] = 32'd4;
        sel       = 1'b1;
        num_pairs = 4'd4;
        start2    = 1'b1;
        tick();
        start2   = 1'b0;
        in_valid = 1'b1;
        in_data  = line;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_busy",  busy2, 0);
        check("t7_issue", dut_issue2, 0);
        check("t7_a",     dut_a2, 0);
        check("t7_done",  done_count2, 0);
        tick();
        tick();
        tick();
        check("t7_ov",    out_valid2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_batch_engine.md
# arith_batch_engine

Single-clock batch sequencer that feeds a fixed-latency pipelined arithmetic unit (multiplier, divider, adder under test) from one host cache line. It unpacks up to `MAX_PAIRS` operand pairs per line, issues them at a programmable interval, and captures each result after exactly `PIPELINE_STAGE` cycles. It then packs the results with a status word into one output line for the host write path. It sits between the AFU's CSR/read-response logic and its write-request logic, and replaces the half-rate single-pair harness.

## Interface
- `DATA_LEN`, 32: operand and result width.
- `LINE_BITS`, 512: cache-line width.
- `PIPELINE_STAGE`, 2: DUT latency in clk cycles, issue to valid `dut_result`. Must be ≥1.
- `ISSUE_INTERVAL`, 1: cycles between successive issues. Must be ≥1; 2 models the old half-rate behaviour.
- `MAX_PAIRS`, derived: `LINE_BITS/(2*DATA_LEN)`. Elaboration error if `32+MAX_PAIRS*DATA_LEN > LINE_BITS`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; clears everything.
- `soft_reset`  in  1  CSR-driven flush pulse.
- `start`  in  1  one-cycle start pulse.
- `num_pairs`  in  `$clog2(MAX_PAIRS+1)`  pair count, sampled with `start`.
- `in_valid` / `in_ready`  in / out  1  operand-line handshake.
- `in_data`  in  `LINE_BITS`  pair i: a at `[2i*DATA_LEN +: DATA_LEN]`, b at `[(2i+1)*DATA_LEN +: DATA_LEN]`.
- `dut_issue`  out  1  one-cycle pulse per issued pair.
- `dut_a`, `dut_b`  out  `DATA_LEN`  operands; zero when `dut_issue`=0.
- `dut_result`  in  `DATA_LEN`  DUT output.
- `out_valid` / `out_ready`  out / in  1  result-line handshake.
- `out_data`  out  `LINE_BITS`  status in `[31:0]`; result i at `[32+i*DATA_LEN +: DATA_LEN]`; unused bits 0.
- `busy`  out  1  state ≠ IDLE.
- `done_count`  out  32  completed batches, wraps at 2^32.

## Operation
- Reset values: `in_ready`, `out_valid`, `dut_issue`, `busy` = 0; `dut_a`, `dut_b`, `out_data`, `done_count` = 0; state IDLE.
- Status word: bit0 = done (1); bit1 = clamped; bits[15:8] = pairs processed; others 0.
- **IDLE**: on `start`, latch `num_pairs`.
  - If `num_pairs` > `MAX_PAIRS`: use `MAX_PAIRS` and set clamped.
  - If the count is 0: go to RESPOND with count 0 and all results zero, skipping input.
  - Otherwise go to WAIT_LINE.
- **WAIT_LINE**: `in_ready`=1. On `in_valid&in_ready`, latch the line and go to ISSUE.
- **ISSUE**: issue pair k (k=0..N-1) every `ISSUE_INTERVAL` cycles, first issue on the first ISSUE cycle. After the last issue go to DRAIN.
- **Capture** (any state except FLUSH): a valid tracker delays `dut_issue` by `PIPELINE_STAGE`. When the delayed valid is set, write `dut_result` into the next result slot and increment the capture counter.
- **DRAIN**: when the capture count = N, go to RESPOND.
- **RESPOND**: `out_valid`=1; `out_data` is stable until `out_ready`. On the handshake: `done_count`++, clear result slots, go to IDLE.
- **FLUSH**: entered from any state on `soft_reset`.
  - On entry: drop `out_valid`/`in_ready`/`dut_issue`, clear tracker, counters and result slots.
  - Remain `PIPELINE_STAGE` cycles so in-flight results are discarded, then go to IDLE.
  - `done_count` is preserved.
- Simultaneous events:
  - `soft_reset` beats `start` and any handshake in the same cycle.
  - `start` outside IDLE is ignored.
  - `reset` mid-batch returns to reset values next cycle.

## Timing
- Line accepted at edge T: pair k issued in cycle T+1+k·I. Result k is sampled at the end of cycle T+1+k·I+P. `out_valid` rises in cycle T+2+(N−1)·I+P.
  - N=8, I=1, P=2: `out_valid` at T+11.
  - N=1, I=2, P=2: `out_valid` at T+4.
- `num_pairs`=0: `out_valid` at start+1.
- FLUSH: lasts exactly P cycles; `in_ready` can first assert P+2 cycles after `soft_reset` (via a new `start`).
- Back-to-back: `start` accepted the cycle after the RESPOND handshake.

## Structure
- Package `arith_batch_pkg`: state enum (IDLE, WAIT_LINE, ISSUE, DRAIN, RESPOND, FLUSH); `STATUS_DONE_BIT`=0, `STATUS_CLAMP_BIT`=1, `STATUS_COUNT_LSB`=8; `RESULT_BASE`=32; operand/result slice functions.
- Sub-module `issue_latency_tracker`: P-deep valid shift register with synchronous flush input.

## Test plan
- N=2, I=1, P=2, line with (3,5),(7,11), multiplier DUT -> `out_data[31:0]`=0x201, results 15 and 77 at bits 32/64, `out_valid` at T+5.
- N=8, I=2, pairs (i,i+1) -> results i·(i+1), `out_valid` at T+18, `dut_issue` pulses spaced 2 cycles.
- `num_pairs`=12 with MAX_PAIRS=8 -> 8 results, status 0x803.
- `num_pairs`=0 -> no `in_ready`, `out_valid` at start+1, status 0x001, `done_count` +1.
- `soft_reset` during ISSUE after 3 issues -> no capture in next P cycles, then IDLE. Following N=1 (6,7) batch returns 42, `done_count` unchanged by flush.
- Hold `out_ready`=0 for 10 cycles -> `out_data` stable, `start` ignored. After the handshake `done_count` increments once.
